// File: rtl/serial_tx.sv
// Register-programmed UART transmitter: 16-entry byte FIFO feeding an 8N1 serializer.
// tx_status = {overflow, busy, 25'b0, fifo_count}, registered one cycle behind internal state.
module serial_tx #(
  parameter int unsigned CLK_DIV = 427,
  parameter logic [7:0]  TX_ADDR = 8'h09
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        reg_wen,
  input  logic [7:0]  reg_addr,
  input  logic [31:0] reg_wdata,
  output logic        txd,
  output logic [31:0] tx_status
);

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned PTR_W  = 4;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned BAUD_W = 16;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]  FULL      = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state;
  logic [7:0]        mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic [BAUD_W-1:0] baud;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift;

  logic wr_hit;
  logic flush;
  logic push;
  logic push_ok;
  logic pop;
  logic baud_done;
  logic unused_wdata;

  assign wr_hit    = reg_wen && (reg_addr == TX_ADDR);
  assign flush     = wr_hit && reg_wdata[31];
  assign push      = wr_hit && !reg_wdata[31];
  // A full FIFO still accepts a push when the head is leaving in the same cycle.
  assign pop       = (state == IDLE) && (count != '0) && !flush;
  assign push_ok   = push && ((count != FULL) || pop);
  assign baud_done = (baud == BAUD_LAST);
  assign unused_wdata = ^reg_wdata[30:8];

  // FIFO storage; contents are don't-care outside the count window, so no reset.
  always_ff @(posedge sysclk) begin
    if (!reset && push_ok) begin
      mem[wr_ptr] <= reg_wdata[7:0];
    end
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge sysclk) begin
    if (reset || flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !push_ok) begin
        overflow <= 1'b1;
      end
      unique case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Serializer FSM; txd is assigned on each transition so the line comes straight from a flop.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state   <= IDLE;
      txd     <= 1'b1;
      baud    <= '0;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          txd  <= 1'b1;
          baud <= '0;
          if (pop) begin
            shift <= mem[rd_ptr];
            state <= START;
            txd   <= 1'b0;
          end
        end
        START: begin
          if (baud_done) begin
            baud    <= '0;
            bit_cnt <= '0;
            state   <= DATA;
            txd     <= shift[0];
          end else begin
            baud <= baud + 1'b1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud <= '0;
            if (bit_cnt == 3'd7) begin
              state <= STOP;
              txd   <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              txd     <= shift[1];
              shift   <= {1'b0, shift[7:1]};
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        STOP: begin
          if (baud_done) begin
            baud  <= '0;
            state <= IDLE;
            txd   <= 1'b1;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          txd   <= 1'b1;
          baud  <= '0;
        end
      endcase
    end
  end

  // Status snapshot, one cycle behind the state it reports.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      tx_status <= '0;
    end else begin
      tx_status <= {overflow, (state != IDLE), 25'b0, count};
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: stimulus pushes expected bytes into a scoreboard queue,
// a line monitor decodes txd frames and pops/compares them independently.
module tb_serial_tx;

  localparam int unsigned CLK_DIV = 4;
  localparam logic [7:0]  TX_ADDR = 8'h09;
  localparam int unsigned FRAME   = 10 * CLK_DIV;

  logic        sysclk;
  logic        reset;
  logic        reg_wen;
  logic [7:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic        txd;
  logic [31:0] tx_status;

  serial_tx #(.CLK_DIV(CLK_DIV), .TX_ADDR(TX_ADDR)) dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .reg_wen   (reg_wen),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .txd       (txd),
    .tx_status (tx_status)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  int         vectors = 0;
  int         errors  = 0;
  int         cyc     = 0;
  int         frames_done = 0;
  logic [7:0] exp_q [$];
  int         starts [$];
  logic       mon_busy = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Line monitor: capture 40 samples from the start edge, check shape, score the byte.
  initial begin : monitor
    int         idx;
    logic [39:0] samp;
    idx  = 0;
    samp = '1;
    forever begin
      @(negedge sysclk);
      cyc++;
      if (reset) begin
        mon_busy = 1'b0;
        idx = 0;
      end else if (!mon_busy) begin
        if (txd === 1'b0) begin
          mon_busy = 1'b1;
          samp = '1;
          samp[0] = 1'b0;
          idx = 1;
          starts.push_back(cyc);
        end
      end else begin
        samp[idx] = txd;
        idx++;
        if (idx == int'(FRAME)) begin
          logic       ok;
          logic [7:0] b;
          logic [3:0] s;
          ok = (samp[3:0] == 4'h0) && (samp[39:36] == 4'hF);
          for (int i = 0; i < 8; i++) begin
            s = samp[4 + 4*i +: 4];
            if (s != 4'h0 && s != 4'hF) ok = 1'b0;
            b[i] = s[0];
          end
          chk("frame_format", 32'(ok), 32'd1);
          if (exp_q.size() == 0) begin
            vectors++;
            errors++;
            $display("FAIL unexpected_frame: got byte 0x%02h expected no frame (cycle %0d)", b, cyc);
          end else begin
            chk("frame_byte", 32'(b), 32'(exp_q.pop_front()));
          end
          mon_busy = 1'b0;
          idx = 0;
          frames_done++;
        end
      end
    end
  end

  task automatic reg_write(input logic [7:0] a, input logic [31:0] d, input logic en);
    @(posedge sysclk); #1;
    reg_wen = en; reg_addr = a; reg_wdata = d;
    @(posedge sysclk); #1;
    reg_wen = 1'b0;
  endtask

  task automatic burst(input int n, input logic [7:0] base);
    @(posedge sysclk); #1;
    for (int i = 0; i < n; i++) begin
      reg_wen = 1'b1; reg_addr = TX_ADDR; reg_wdata = {24'h0, 8'(base + i)};
      @(posedge sysclk); #1;
    end
    reg_wen = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < budget) begin
      @(posedge sysclk);
      n++;
    end
    if (n >= budget) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (3) @(posedge sysclk);
    #1;
  endtask

  initial begin : stimulus
    int busy_cnt;
    int low_cnt;
    int fd0;
    int n;
    reset = 1'b1; reg_wen = 1'b0; reg_addr = '0; reg_wdata = '0;

    // Reset state
    repeat (3) @(posedge sysclk);
    #1;
    chk("reset_txd", 32'(txd), 32'd1);
    chk("reset_status", tx_status, 32'h0);
    reset = 1'b0;

    // Writes to the wrong address or without the strobe are ignored
    reg_write(8'h0A, 32'h55, 1'b1);
    reg_write(TX_ADDR, 32'h55, 1'b0);
    low_cnt = 0;
    repeat (12) begin
      @(negedge sysclk);
      if (txd !== 1'b1) low_cnt++;
    end
    chk("ignored_txd_low_cycles", 32'(low_cnt), 32'd0);
    chk("ignored_status", tx_status, 32'h0);

    // Single byte: latency, bit pattern (monitor) and busy width
    exp_q.push_back(8'hA5);
    reg_write(TX_ADDR, 32'h0000_00A5, 1'b1);
    chk("latency_n1_txd", 32'(txd), 32'd1);
    @(posedge sysclk); #1;
    chk("latency_n2_txd", 32'(txd), 32'd0);
    busy_cnt = 0;
    repeat (60) begin
      @(negedge sysclk);
      if (tx_status[30]) busy_cnt++;
    end
    chk("busy_cycles", 32'(busy_cnt), 32'd40);
    drain(100);

    // 17 back-to-back writes: one popped, 16 queued, no overflow, 41-cycle frame spacing
    starts.delete();
    for (int i = 0; i < 17; i++) exp_q.push_back(8'(i));
    burst(17, 8'h00);
    @(posedge sysclk); #1;
    chk("burst17_status", tx_status, 32'h4000_0010);
    drain(900);
    chk("burst17_frames", 32'(starts.size()), 32'd17);
    for (int i = 1; i < starts.size(); i++)
      chk("frame_spacing", 32'(starts[i] - starts[i-1]), 32'(FRAME + 1));
    chk("burst17_idle_status", tx_status, 32'h0);

    // Full FIFO: drop sets overflow; push coinciding with pop is accepted
    for (int i = 0; i < 17; i++) exp_q.push_back(8'(8'h20 + i));
    burst(17, 8'h20);
    @(posedge sysclk); #1;
    chk("full_status", tx_status, 32'h4000_0010);
    reg_write(TX_ADDR, 32'h0000_0077, 1'b1);
    @(posedge sysclk); #1;
    chk("overflow_status", tx_status, 32'hC000_0010);
    fd0 = frames_done;
    n = 0;
    while (frames_done == fd0 && n < 100) begin
      @(posedge sysclk);
      n++;
    end
    if (n >= 100) chk("pop_wait_timeout", 32'(frames_done - fd0), 32'd1);
    #1;
    reg_wen = 1'b1; reg_addr = TX_ADDR; reg_wdata = 32'h0000_0077;
    exp_q.push_back(8'h77);
    @(posedge sysclk); #1;
    reg_wen = 1'b0;
    @(posedge sysclk); #1;
    chk("pushpop_status", tx_status, 32'hC000_0010);
    drain(900);
    chk("overflow_sticky", tx_status, 32'h8000_0000);

    // Flush mid-frame with 5 queued: current frame completes, nothing else, overflow cleared
    exp_q.push_back(8'hA0);
    burst(6, 8'hA0);
    repeat (10) @(posedge sysclk);
    fd0 = frames_done;
    reg_write(TX_ADDR, 32'h8000_0000, 1'b1);
    @(posedge sysclk); #1;
    chk("flush_status", tx_status, 32'h4000_0000);
    drain(100);
    repeat (200) @(posedge sysclk);
    #1;
    chk("flush_frame_count", 32'(frames_done - fd0), 32'd1);
    chk("flush_idle_status", tx_status, 32'h0);

    // Reset during DATA bit 3 aborts the frame; a write during reset is ignored
    exp_q.push_back(8'hC3);
    reg_write(TX_ADDR, 32'h0000_00C3, 1'b1);
    repeat (17) @(posedge sysclk);
    #1;
    chk("bit3_txd_low", 32'(txd), 32'd0);
    reset = 1'b1;
    exp_q.delete();
    @(posedge sysclk); #1;
    chk("midframe_reset_txd", 32'(txd), 32'd1);
    chk("midframe_reset_status", tx_status, 32'h0);
    reg_wen = 1'b1; reg_addr = TX_ADDR; reg_wdata = 32'h0000_0011;
    @(posedge sysclk); #1;
    reg_wen = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge sysclk);
    #1;
    chk("reset_write_ignored_status", tx_status, 32'h0);
    chk("reset_write_ignored_txd", 32'(txd), 32'd1);
    exp_q.push_back(8'h3C);
    reg_write(TX_ADDR, 32'h0000_003C, 1'b1);
    drain(100);
    chk("final_status", tx_status, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected under 20000", cyc);
    $fatal(1);
  end

endmodule
